// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between NREQ requesters with a fixed 3-cycle read.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default is fixed priority.
module rom_arbiter #(
  parameter int NREQ  = 2,
  parameter int SIZE  = 2048,
  parameter int WIDTH = 16,
  parameter int ASIZE = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ASIZE-1:0] addr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy,
  output logic                  rom_en,
  output logic [ASIZE-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   win;
  logic            any_req;

  assign any_req = |req;
  assign busy    = (state != IDLE);

`ifdef ROM_ARB_RR_EN
  logic [IW-1:0] last;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last) + 1 + k) % NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k[IW-1:0]]) win = k[IW-1:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
`ifdef ROM_ARB_RR_EN
      last     <= IW'(NREQ - 1);
`endif
    end else begin
      gnt      <= '0;
      rd_valid <= '0;
      rom_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel      <= win;
            rom_addr <= addr[int'(win)*ASIZE +: ASIZE];
            gnt      <= NREQ'(1) << win;
            rom_en   <= 1'b1;
            state    <= ISSUE;
`ifdef ROM_ARB_RR_EN
            last     <= win;
`endif
          end
        end
        ISSUE: state <= DATA;
        // ROM output is valid here, one cycle after the enable was sampled.
        DATA: begin
          rd_data  <= rom_dout;
          rd_valid <= NREQ'(1) << sel;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
